// File: rtl/dense_forward_engine_pkg.sv
// dense_forward_engine_pkg: shared dimensions, FSM state type and a width helper for the dense forward pass
package dense_forward_engine_pkg;
    localparam int HID_DIM  = 16;
    localparam int CHAR_NUM = 4;
    localparam int N_LEN    = 16;
    localparam int N_LEN_W  = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
    function automatic int clog2(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction
endpackage

// File: rtl/dense_forward_engine_inner_lanes.sv
// dense_inner_lanes: DATA_N signed multiply lanes feeding a registered adder tree, tag carried alongside
// Ports: clk, rst; flush_i drops every in-flight tag; valid_i/tag_i accompany w_i (DATA_N weights)
// and d_i (DATA_N inputs); valid_o/tag_o/sum_o emerge INNER_LAT cycles later (INNER_LAT >= 2),
// sum_o is the sign-extended sum of the products each shifted right arithmetically by FRAC_W.
module dense_inner_lanes
    import dense_forward_engine_pkg::*;
#(
    parameter int DATA_N    = 8,
    parameter int W_W       = 16,
    parameter int D_W       = 16,
    parameter int FRAC_W    = 8,
    parameter int INNER_LAT = 3,
    parameter int TAG_W     = 4,
    parameter int S_W       = W_W + D_W - FRAC_W + clog2(DATA_N) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [TAG_W-1:0]      tag_i,
    input  logic [DATA_N*W_W-1:0] w_i,
    input  logic [DATA_N*D_W-1:0] d_i,
    output logic                  valid_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic [S_W-1:0]        sum_o
);
    localparam int F_W = W_W + D_W;
    localparam int P_W = F_W - FRAC_W;
    logic signed [F_W-1:0] prod [DATA_N];
    logic signed [P_W-1:0] prod_q [DATA_N];
    logic signed [S_W-1:0] tree;
    logic signed [S_W-1:0] sum_q [INNER_LAT-1];
    logic                  v_q [INNER_LAT];
    logic [TAG_W-1:0]      t_q [INNER_LAT];
    always_comb begin
        tree = '0;
        for (int i = 0; i < DATA_N; i++) begin
            prod[i] = F_W'($signed(w_i[i*W_W +: W_W])) * F_W'($signed(d_i[i*D_W +: D_W]));
            tree = tree + S_W'(prod_q[i]);
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_N; i++) prod_q[i] <= P_W'(prod[i] >>> FRAC_W);
        sum_q[0] <= tree;
        for (int j = 1; j < INNER_LAT - 1; j++) sum_q[j] <= sum_q[j-1];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < INNER_LAT; j++) begin
                v_q[j] <= 1'b0;
                t_q[j] <= '0;
            end
        end else begin
            v_q[0] <= valid_i && !flush_i;
            t_q[0] <= tag_i;
            for (int j = 1; j < INNER_LAT; j++) begin
                v_q[j] <= v_q[j-1] && !flush_i;
                t_q[j] <= t_q[j-1];
            end
        end
    end
    assign valid_o = v_q[INNER_LAT-1];
    assign tag_o   = t_q[INNER_LAT-1];
    assign sum_o   = sum_q[INNER_LAT-2];
endmodule

// File: rtl/dense_forward_engine.sv
// dense_forward_engine: dense-layer forward pass q[o] = fmt(sum_k W[o][k]*d[k]) with weights streamed from RAM
// Ports: clk, rst (sync, active high); run level enable; d input vector (element k at [k*D_W +: D_W]);
// raddr weight RAM word address (row*CH + chunk); rdata DATA_N weights, valid 1 cycle after raddr;
// valid result complete and held while run stays high; q output vector (element o at [o*W_W +: W_W]).
// Define DENSE_FWD_SAT_EN to clamp results to the W_W signed range instead of wrapping.
module dense_forward_engine
    import dense_forward_engine_pkg::*;
#(
    parameter int IN_DIM    = HID_DIM,
    parameter int OUT_DIM   = CHAR_NUM,
    parameter int DATA_N    = 8,
    parameter int W_W       = N_LEN,
    parameter int D_W       = N_LEN_W,
    parameter int FRAC_W    = N_LEN_W - 1,
    parameter int INNER_LAT = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     run,
    input  logic [IN_DIM*D_W-1:0]                    d,
    output logic [clog2(OUT_DIM*IN_DIM/DATA_N)-1:0] raddr,
    input  logic [DATA_N*W_W-1:0]                    rdata,
    output logic                                     valid,
    output logic [OUT_DIM*W_W-1:0]                   q
);
    localparam int CH    = IN_DIM / DATA_N;
    localparam int A_W   = clog2(OUT_DIM * CH);
    localparam int R_W   = clog2(OUT_DIM);
    localparam int C_W   = clog2(CH);
    localparam int S_W   = W_W + D_W - FRAC_W + clog2(DATA_N) + 1;
    localparam int ACC_W = S_W + C_W + 1;
`ifdef DENSE_FWD_SAT_EN
    localparam logic signed [ACC_W-1:0] Q_MAX = {{(ACC_W-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Q_MIN = {{(ACC_W-W_W+1){1'b1}}, {(W_W-1){1'b0}}};
`endif
    state_e                   state_q, state_d;
    logic [A_W-1:0]           raddr_q, raddr_d;
    logic [R_W-1:0]           row_q, row_d, rd_row_q, o_row;
    logic [C_W-1:0]           chunk_q, chunk_d, rd_chunk_q, o_chunk;
    logic                     rd_v_q, o_v, issue, last_addr, use_o, o_last, fin, valid_q;
    logic [DATA_N*D_W-1:0]    d_ch [CH];
    logic [R_W+C_W-1:0]       o_tag;
    logic [S_W-1:0]           o_sum;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [W_W-1:0]           q_q [OUT_DIM];
    logic [W_W-1:0]           q_word;
    for (genvar c = 0; c < CH; c++) assign d_ch[c] = d[c*DATA_N*D_W +: DATA_N*D_W];
    for (genvar g = 0; g < OUT_DIM; g++) assign q[g*W_W +: W_W] = q_q[g];
    dense_inner_lanes #(
        .DATA_N(DATA_N), .W_W(W_W), .D_W(D_W), .FRAC_W(FRAC_W),
        .INNER_LAT(INNER_LAT), .TAG_W(R_W + C_W), .S_W(S_W)
    ) u_lanes (
        .clk(clk), .rst(rst), .flush_i(!run),
        .valid_i(rd_v_q), .tag_i({rd_row_q, rd_chunk_q}), .w_i(rdata), .d_i(d_ch[rd_chunk_q]),
        .valid_o(o_v), .tag_o(o_tag), .sum_o(o_sum)
    );
    assign {o_row, o_chunk} = o_tag;
    // IDLE issues address 0 on the run edge itself, so the first RAM read costs no extra cycle
    always_comb begin
        issue     = run && (state_q == IDLE || state_q == ISSUE);
        last_addr = row_q == R_W'(OUT_DIM - 1) && chunk_q == C_W'(CH - 1);
        use_o     = o_v && run;
        o_last    = o_chunk == C_W'(CH - 1);
        fin       = use_o && o_last && o_row == R_W'(OUT_DIM - 1);
        acc_d     = (o_chunk == '0 ? '0 : acc_q) + ACC_W'($signed(o_sum));
        state_d   = !run ? IDLE : issue ? (last_addr ? DRAIN : ISSUE) : (state_q == DRAIN && fin) ? DONE : state_q;
        chunk_d   = !run ? '0 : (issue && !last_addr) ? (chunk_q == C_W'(CH - 1) ? '0 : chunk_q + C_W'(1)) : chunk_q;
        row_d     = !run ? '0 : (issue && !last_addr && chunk_q == C_W'(CH - 1)) ? row_q + R_W'(1) : row_q;
        raddr_d   = !run ? '0 : (issue && !last_addr) ? raddr_q + A_W'(1) : raddr_q;
`ifdef DENSE_FWD_SAT_EN
        q_word    = acc_d > Q_MAX ? W_W'(Q_MAX) : acc_d < Q_MIN ? W_W'(Q_MIN) : acc_d[W_W-1:0];
`else
        q_word    = acc_d[W_W-1:0];
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            raddr_q    <= '0;
            row_q      <= '0;
            chunk_q    <= '0;
            rd_v_q     <= 1'b0;
            rd_row_q   <= '0;
            rd_chunk_q <= '0;
            acc_q      <= '0;
            valid_q    <= 1'b0;
            for (int o = 0; o < OUT_DIM; o++) q_q[o] <= '0;
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            row_q      <= row_d;
            chunk_q    <= chunk_d;
            rd_v_q     <= issue;
            rd_row_q   <= row_q;
            rd_chunk_q <= chunk_q;
            valid_q    <= run && state_q == DONE;
            if (use_o) acc_q <= acc_d;
            if (use_o && o_last) q_q[o_row] <= q_word;
        end
    end
    assign raddr = raddr_q;
    assign valid = valid_q;
endmodule
